video_pattern_gen: RTL and testbench



---
 rtl/video_pkg.sv | 49 ++++
 rtl/video_timing_core.sv | 66 ++++++
 rtl/video_pattern_gen.sv | 206 ++++++++++++++++++++
 tb/tb_video_pattern_gen.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared types and constants for the video pattern generator.
//   pat_mode_t   : runtime pattern select (solid, colour bars, checkerboard, grid)
//   COL_*        : 24-bit {R,G,B} constants for the eight colour bars
//   timing_total : sums active + porches + sync into a line/frame total
package video_pkg;

    localparam int unsigned CNT_W = 12;
    localparam int unsigned RGB_W = 24;

    typedef enum logic [1:0] {
        PAT_SOLID = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_GRID  = 2'd3
    } pat_mode_t;

    localparam logic [RGB_W-1:0] COL_WHITE   = 24'hFFFFFF;
    localparam logic [RGB_W-1:0] COL_YELLOW  = 24'hFFFF00;
    localparam logic [RGB_W-1:0] COL_CYAN    = 24'h00FFFF;
    localparam logic [RGB_W-1:0] COL_GREEN   = 24'h00FF00;
    localparam logic [RGB_W-1:0] COL_MAGENTA = 24'hFF00FF;
    localparam logic [RGB_W-1:0] COL_RED     = 24'hFF0000;
    localparam logic [RGB_W-1:0] COL_BLUE    = 24'h0000FF;
    localparam logic [RGB_W-1:0] COL_BLACK   = 24'h000000;

    function automatic int unsigned timing_total(input int unsigned active,
                                                 input int unsigned fp,
                                                 input int unsigned sync,
                                                 input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    // Bar colour by bar index, left to right.
    function automatic logic [RGB_W-1:0] bar_colour(input logic [2:0] idx);
        logic [RGB_W-1:0] c;
        case (idx)
            3'd0:    c = COL_WHITE;
            3'd1:    c = COL_YELLOW;
            3'd2:    c = COL_CYAN;
            3'd3:    c = COL_GREEN;
            3'd4:    c = COL_MAGENTA;
            3'd5:    c = COL_RED;
            3'd6:    c = COL_BLUE;
            default: c = COL_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/video_timing_core.sv
// Raster timing core: horizontal/vertical counters and combinational decodes.
//   pixclk, reset  : pixel clock, asynchronous active-high reset
//   hcnt, vcnt     : registered raster position
//   active_c       : position is inside the visible area
//   hsync_c/vsync_c: sync interval (asserted, polarity-free)
//   frame_start_c  : position is (0,0)
//   line_end_c     : last pixel of a line (hcnt about to wrap)
module video_timing_core
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic             pixclk,
    input  logic             reset,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic             active_c,
    output logic             hsync_c,
    output logic             vsync_c,
    output logic             frame_start_c,
    output logic             line_end_c
);

    localparam int unsigned H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    // Counters are 12 bits; totals must fit.
    if (H_TOTAL >= 4096 || V_TOTAL >= 4096) begin : g_total_check
        $error("video_timing_core: H_TOTAL/V_TOTAL must be below 4096");
    end
    if (H_ACTIVE % 8 != 0) begin : g_active_check
        $error("video_timing_core: H_ACTIVE must be a multiple of 8");
    end

    logic frame_end_c;

    assign line_end_c    = (hcnt == CNT_W'(H_TOTAL - 1));
    assign frame_end_c   = line_end_c && (vcnt == CNT_W'(V_TOTAL - 1));
    assign active_c      = (hcnt < CNT_W'(H_ACTIVE)) && (vcnt < CNT_W'(V_ACTIVE));
    assign hsync_c       = (hcnt >= CNT_W'(H_ACTIVE + H_FP)) &&
                           (hcnt <  CNT_W'(H_ACTIVE + H_FP + H_SYNC));
    assign vsync_c       = (vcnt >= CNT_W'(V_ACTIVE + V_FP)) &&
                           (vcnt <  CNT_W'(V_ACTIVE + V_FP + V_SYNC));
    assign frame_start_c = (hcnt == '0) && (vcnt == '0);

    // Raster position; vcnt steps on each line wrap.
    always_ff @(posedge pixclk or posedge reset) begin
        if (reset) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (line_end_c) begin
            hcnt <= '0;
            vcnt <= frame_end_c ? '0 : vcnt + CNT_W'(1);
        end else begin
            hcnt <= hcnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/video_pattern_gen.sv
// Video test-pattern source feeding the three TMDS encoders.
//   pixclk, reset : pixel clock, asynchronous active-high reset
//   mode          : 0 solid, 1 colour bars, 2 checkerboard, 3 grid (frame-latched)
//   solid_rgb     : {R,G,B} for solid mode, sampled every pixel
//   VDE, CD       : video data enable, {vsync, hsync}
//   R/G/B_data    : registered pixel colour (zero outside active area)
//   x, y          : raster position aligned with the outputs
//   frame_start   : one-cycle pulse with pixel (0,0)
// Optional build macro PATTERN_SCROLL_EN: horizontal scroll of bars/checkerboard,
// advancing one pixel per frame.
module video_pattern_gen
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter logic        SYNC_POL   = 1'b0,
    parameter int unsigned CHECK_LOG2 = 5,
    parameter int unsigned GRID_LOG2  = 4
) (
    input  logic             pixclk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic [RGB_W-1:0] solid_rgb,
    output logic             VDE,
    output logic [1:0]       CD,
    output logic [7:0]       R_data,
    output logic [7:0]       G_data,
    output logic [7:0]       B_data,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             frame_start
);

    localparam int unsigned     BAR_W     = H_ACTIVE / 8;
    localparam logic [CNT_W-1:0] GRID_MASK = CNT_W'((1 << GRID_LOG2) - 1);

    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] vcnt;
    logic             active_c;
    logic             hsync_c;
    logic             vsync_c;
    logic             frame_start_c;
    logic             line_end_c;

    video_timing_core #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .pixclk        (pixclk),
        .reset         (reset),
        .hcnt          (hcnt),
        .vcnt          (vcnt),
        .active_c      (active_c),
        .hsync_c       (hsync_c),
        .vsync_c       (vsync_c),
        .frame_start_c (frame_start_c),
        .line_end_c    (line_end_c)
    );

    // Mode is taken live on pixel (0,0) and held for the rest of the frame.
    pat_mode_t mode_q;
    pat_mode_t mode_eff_c;

    assign mode_eff_c = frame_start_c ? pat_mode_t'(mode) : mode_q;

    always_ff @(posedge pixclk or posedge reset) begin
        if (reset) begin
            mode_q <= PAT_SOLID;
        end else if (frame_start_c) begin
            mode_q <= pat_mode_t'(mode);
        end
    end

    // Horizontal pattern coordinate and the values the bar counters restart from.
    logic [CNT_W-1:0] hx_c;
    logic [CNT_W-1:0] bar_load_pix_c;
    logic [2:0]       bar_load_idx_c;

`ifdef PATTERN_SCROLL_EN
    localparam int unsigned V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    logic [CNT_W-1:0] offset;
    logic [CNT_W-1:0] off_pix;
    logic [2:0]       off_bar;
    logic [CNT_W-1:0] offset_nx_c;
    logic [CNT_W-1:0] off_pix_nx_c;
    logic [2:0]       off_bar_nx_c;
    logic             frame_end_c;
    logic [CNT_W:0]   hx_sum_c;

    assign frame_end_c = line_end_c && (vcnt == CNT_W'(V_TOTAL - 1));

    // Offset steps on the last pixel of a frame so the whole next frame,
    // including pixel (0,0), sees one consistent offset. off_pix/off_bar
    // track offset as (offset mod BAR_W, offset / BAR_W) without a divider.
    always_comb begin
        offset_nx_c  = offset;
        off_pix_nx_c = off_pix;
        off_bar_nx_c = off_bar;
        if (frame_end_c) begin
            offset_nx_c = (offset == CNT_W'(H_ACTIVE - 1)) ? '0 : offset + CNT_W'(1);
            if (off_pix == CNT_W'(BAR_W - 1)) begin
                off_pix_nx_c = '0;
                off_bar_nx_c = off_bar + 3'd1;
            end else begin
                off_pix_nx_c = off_pix + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge pixclk or posedge reset) begin
        if (reset) begin
            offset  <= '0;
            off_pix <= '0;
            off_bar <= '0;
        end else begin
            offset  <= offset_nx_c;
            off_pix <= off_pix_nx_c;
            off_bar <= off_bar_nx_c;
        end
    end

    // (hcnt + offset) mod H_ACTIVE; both operands are below H_ACTIVE in the active area.
    assign hx_sum_c       = {1'b0, hcnt} + {1'b0, offset};
    assign hx_c           = (hx_sum_c >= (CNT_W+1)'(H_ACTIVE)) ?
                            CNT_W'(hx_sum_c - (CNT_W+1)'(H_ACTIVE)) : hx_sum_c[CNT_W-1:0];
    assign bar_load_pix_c = off_pix_nx_c;
    assign bar_load_idx_c = off_bar_nx_c;
`else
    assign hx_c           = hcnt;
    assign bar_load_pix_c = '0;
    assign bar_load_idx_c = '0;
`endif

    // Bar position counters: pixel within bar and bar index, restarted each line.
    logic [CNT_W-1:0] bar_pix;
    logic [2:0]       bar_idx;

    always_ff @(posedge pixclk or posedge reset) begin
        if (reset) begin
            bar_pix <= '0;
            bar_idx <= '0;
        end else if (line_end_c) begin
            bar_pix <= bar_load_pix_c;
            bar_idx <= bar_load_idx_c;
        end else if (bar_pix == CNT_W'(BAR_W - 1)) begin
            bar_pix <= '0;
            bar_idx <= bar_idx + 3'd1;
        end else begin
            bar_pix <= bar_pix + CNT_W'(1);
        end
    end

    // Pattern colour for the current position.
    logic             check_c;
    logic             grid_c;
    logic [RGB_W-1:0] rgb_c;

    assign check_c = (((hx_c ^ vcnt) >> CHECK_LOG2) & CNT_W'(1)) != '0;
    assign grid_c  = ((hcnt & GRID_MASK) == '0) || ((vcnt & GRID_MASK) == '0) ||
                     (hcnt == CNT_W'(H_ACTIVE - 1));

    always_comb begin
        rgb_c = COL_BLACK;
        case (mode_eff_c)
            PAT_SOLID: rgb_c = solid_rgb;
            PAT_BARS:  rgb_c = bar_colour(bar_idx);
            PAT_CHECK: rgb_c = check_c ? COL_WHITE : COL_BLACK;
            PAT_GRID:  rgb_c = grid_c  ? COL_WHITE : COL_BLACK;
            default:   rgb_c = COL_BLACK;
        endcase
    end

    // Output stage: everything leaves one cycle after the counter state.
    always_ff @(posedge pixclk or posedge reset) begin
        if (reset) begin
            VDE                      <= 1'b0;
            CD                       <= {~SYNC_POL, ~SYNC_POL};
            {R_data, G_data, B_data} <= '0;
            x                        <= '0;
            y                        <= '0;
            frame_start              <= 1'b0;
        end else begin
            VDE                      <= active_c;
            CD                       <= {vsync_c ? SYNC_POL : ~SYNC_POL,
                                         hsync_c ? SYNC_POL : ~SYNC_POL};
            {R_data, G_data, B_data} <= active_c ? rgb_c : '0;
            x                        <= hcnt;
            y                        <= vcnt;
            frame_start              <= frame_start_c;
        end
    end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Self-checking bench for video_pattern_gen on a small 24x12 raster.
module tb_video_pattern_gen;

    localparam int HA = 16, HFP = 2, HS = 3, HBP = 3, HT = 24;
    localparam int VA = 8,  VFP = 1, VS = 2, VBP = 1, VT = 12;

    logic        pixclk = 1'b0;
    logic        reset  = 1'b1;
    logic [1:0]  mode   = 2'd0;
    logic [23:0] solid_rgb = 24'h123456;
    logic        VDE;
    logic [1:0]  CD;
    logic [7:0]  R_data, G_data, B_data;
    logic [11:0] x, y;
    logic        frame_start;

    video_pattern_gen #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .SYNC_POL (1'b0), .CHECK_LOG2 (1), .GRID_LOG2 (2)
    ) dut (
        .pixclk      (pixclk),
        .reset       (reset),
        .mode        (mode),
        .solid_rgb   (solid_rgb),
        .VDE         (VDE),
        .CD          (CD),
        .R_data      (R_data),
        .G_data      (G_data),
        .B_data      (B_data),
        .x           (x),
        .y           (y),
        .frame_start (frame_start)
    );

    always #5 pixclk = ~pixclk;

    typedef struct packed {
        logic        vde;
        logic [1:0]  cd;
        logic [23:0] rgb;
        logic [11:0] x;
        logic [11:0] y;
        logic        fs;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference raster model state: position the DUT will output after the next edge.
    int          mh, mv, moff;
    logic [1:0]  mq;
    logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    function automatic exp_t observed();
        exp_t o;
        o = {VDE, CD, R_data, G_data, B_data, x, y, frame_start};
        return o;
    endfunction

    task automatic model_reset();
        mh = 0; mv = 0; moff = 0; mq = 2'd0;
        exp_q.delete();
    endtask

    // Push the expected output for the model position, then clock once.
    task automatic tick();
        exp_t        e;
        logic [1:0]  em;
        int          hx;
        logic [23:0] c;
        em = (mh == 0 && mv == 0) ? mode : mq;
        if (mh == 0 && mv == 0) mq = mode;
`ifdef PATTERN_SCROLL_EN
        hx = (mh + moff) % HA;
`else
        hx = mh;
`endif
        case (em)
            2'd0:    c = solid_rgb;
            2'd1:    c = bar_tab[(hx / (HA / 8)) % 8];
            2'd2:    c = (((hx / 2) % 2) != ((mv / 2) % 2)) ? 24'hFFFFFF : 24'h0;
            default: c = ((mh % 4 == 0) || (mv % 4 == 0) || (mh == HA - 1)) ? 24'hFFFFFF : 24'h0;
        endcase
        e.vde = (mh < HA) && (mv < VA);
        e.cd  = {!((mv >= VA + VFP) && (mv < VA + VFP + VS)),
                 !((mh >= HA + HFP) && (mh < HA + HFP + HS))};
        e.rgb = e.vde ? c : 24'h0;
        e.x   = 12'(mh);
        e.y   = 12'(mv);
        e.fs  = (mh == 0) && (mv == 0);
        exp_q.push_back(e);
        mh++;
        if (mh == HT) begin
            mh = 0;
            mv++;
            if (mv == VT) begin
                mv = 0;
                moff = (moff + 1) % HA;
            end
        end
        @(posedge pixclk);
        #1;
    endtask

    // Advance until the next output will be pixel (tx,ty); outputs on the way are skipped.
    task automatic run_to(input int tx, input int ty);
        exp_t d;
        for (int i = 0; i < HT * VT + 2; i++) begin
            if (mh == tx && mv == ty) break;
            tick();
            d = exp_q.pop_front();
        end
    endtask

    task automatic test_reset();
        exp_t e;
        int   cnt;
        bit   seen;
        mode = 2'd0;
        solid_rgb = 24'h123456;
        repeat (3) @(posedge pixclk);
        @(negedge pixclk);
        reset = 1'b0;
        model_reset();
        run_to(7, 2);
        // Assert reset mid-line, between edges.
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if ({VDE, CD, R_data, G_data, B_data, x, y, frame_start} !== {1'b0, 2'b11, 24'h0, 12'h0, 12'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_async: got %h want %h", observed(), {1'b0, 2'b11, 24'h0, 12'h0, 12'h0, 1'b0});
        end
        @(posedge pixclk);
        #1;
        n_checks++;
        if (VDE !== 1'b0 || CD !== 2'b11 || frame_start !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: got vde=%b cd=%b fs=%b want 0 11 0", VDE, CD, frame_start);
        end
        @(negedge pixclk);
        reset = 1'b0;
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (observed() !== e) begin
            n_fail++;
            $display("FAIL reset_first_pixel: got %h want %h", observed(), e);
        end
        n_checks++;
        if (x !== 12'd0 || y !== 12'd0 || frame_start !== 1'b1 || VDE !== 1'b1 || CD !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_first_fields: got x=%0d y=%0d fs=%b vde=%b cd=%b want 0 0 1 1 11",
                     x, y, frame_start, VDE, CD);
        end
        // frame_start period, twice.
        for (int p = 0; p < 2; p++) begin
            cnt = 0;
            seen = 0;
            for (int i = 0; i < 400 && !seen; i++) begin
                tick();
                cnt++;
                e = exp_q.pop_front();
                n_checks++;
                if (observed() !== e) begin
                    n_fail++;
                    $display("FAIL frame_period_px: got %h want %h", observed(), e);
                end
                if (frame_start === 1'b1) seen = 1;
            end
            n_checks++;
            if (!seen || cnt != 288) begin
                n_fail++;
                $display("FAIL frame_start_period: got %0d cycles (seen=%0d) want 288", cnt, seen);
            end
        end
    endtask

    task automatic test_timing();
        exp_t e;
        int   vde_cnt;
        mode = 2'd0;
        run_to(0, 1);
        vde_cnt = 0;
        for (int i = 0; i < HT; i++) begin
            solid_rgb = 24'($urandom);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (observed() !== e) begin
                n_fail++;
                $display("FAIL timing_line_px: got %h want %h", observed(), e);
            end
            n_checks++;
            if (CD[0] !== ((x >= 18 && x <= 20) ? 1'b0 : 1'b1)) begin
                n_fail++;
                $display("FAIL hsync_window: x=%0d got hsync=%b", x, CD[0]);
            end
            if (VDE === 1'b1) vde_cnt++;
        end
        n_checks++;
        if (vde_cnt != 16) begin
            n_fail++;
            $display("FAIL vde_count: got %0d want 16", vde_cnt);
        end
        run_to(0, 8);
        for (int i = 0; i < 4 * HT; i++) begin
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (observed() !== e) begin
                n_fail++;
                $display("FAIL timing_vs_px: got %h want %h", observed(), e);
            end
            n_checks++;
            if (CD[1] !== ((y == 9 || y == 10) ? 1'b0 : 1'b1)) begin
                n_fail++;
                $display("FAIL vsync_window: y=%0d got vsync=%b", y, CD[1]);
            end
        end
    endtask

    task automatic test_bars();
        exp_t        e;
        logic [23:0] prev;
        mode = 2'd1;
        run_to(0, 0);
        run_to(0, 2);
        prev = 24'h0;
        for (int i = 0; i < HT; i++) begin
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (observed() !== e) begin
                n_fail++;
                $display("FAIL bars_px: got %h want %h", observed(), e);
            end
`ifndef PATTERN_SCROLL_EN
            n_checks++;
            if (VDE === 1'b1) begin
                if ({R_data, G_data, B_data} !== bar_tab[x / 2] ||
                    (x % 2 == 1 && {R_data, G_data, B_data} !== prev) ||
                    (x % 2 == 0 && x != 0 && {R_data, G_data, B_data} === prev)) begin
                    n_fail++;
                    $display("FAIL bars_sequence: x=%0d got %h want %h", x, {R_data, G_data, B_data}, bar_tab[x / 2]);
                end
            end else if ({R_data, G_data, B_data} !== 24'h0) begin
                n_fail++;
                $display("FAIL bars_blank: x=%0d got %h want 000000", x, {R_data, G_data, B_data});
            end
`endif
            prev = {R_data, G_data, B_data};
        end
    endtask

    task automatic test_mode_change();
        exp_t e;
        mode = 2'd0;
        solid_rgb = 24'h123456;
        run_to(0, 0);
        run_to(5, 3);
        mode = 2'd2;
        for (int i = 0; i < HT * VT && !(mh == 0 && mv == 0); i++) begin
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (observed() !== e) begin
                n_fail++;
                $display("FAIL mode_hold_px: got %h want %h", observed(), e);
            end
            n_checks++;
            if (VDE === 1'b1 && {R_data, G_data, B_data} !== 24'h123456) begin
                n_fail++;
                $display("FAIL mode_hold_solid: x=%0d y=%0d got %h want 123456", x, y, {R_data, G_data, B_data});
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (observed() !== e) begin
                n_fail++;
                $display("FAIL mode_switch_px: got %h want %h", observed(), e);
            end
`ifndef PATTERN_SCROLL_EN
            if (i == 0 || i == 2) begin
                n_checks++;
                if ({R_data, G_data, B_data} !== ((i == 0) ? 24'h000000 : 24'hFFFFFF)) begin
                    n_fail++;
                    $display("FAIL mode_switch_check: x=%0d got %h want %h", x, {R_data, G_data, B_data},
                             (i == 0) ? 24'h000000 : 24'hFFFFFF);
                end
            end
`endif
        end
    endtask

    task automatic test_grid();
        exp_t        e;
        logic [23:0] want;
        mode = 2'd3;
        run_to(0, 0);
        for (int i = 0; i < HT * VT; i++) begin
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (observed() !== e) begin
                n_fail++;
                $display("FAIL grid_px: got %h want %h", observed(), e);
            end
            if (VDE === 1'b1) begin
                want = ((x inside {0, 4, 8, 12, 15}) || (y inside {0, 4})) ? 24'hFFFFFF : 24'h0;
                n_checks++;
                if ({R_data, G_data, B_data} !== want) begin
                    n_fail++;
                    $display("FAIL grid_rule: x=%0d y=%0d got %h want %h", x, y, {R_data, G_data, B_data}, want);
                end
            end
        end
    endtask

`ifdef PATTERN_SCROLL_EN
    task automatic test_scroll();
        exp_t        e;
        logic [23:0] line [17][16];
        mode = 2'd1;
        run_to(0, 0);
        for (int f = 0; f < 17; f++) begin
            run_to(0, 0);
            for (int i = 0; i < HA; i++) begin
                tick();
                e = exp_q.pop_front();
                n_checks++;
                if (observed() !== e) begin
                    n_fail++;
                    $display("FAIL scroll_px: got %h want %h", observed(), e);
                end
                line[f][i] = {R_data, G_data, B_data};
            end
        end
        for (int f = 0; f < 16; f++) begin
            n_checks++;
            if (line[f + 1][0] !== line[f][1]) begin
                n_fail++;
                $display("FAIL scroll_step: frame %0d x=0 got %h want %h", f + 1, line[f + 1][0], line[f][1]);
            end
        end
        for (int i = 0; i < HA; i++) begin
            n_checks++;
            if (line[16][i] !== line[0][i]) begin
                n_fail++;
                $display("FAIL scroll_wrap: x=%0d got %h want %h", i, line[16][i], line[0][i]);
            end
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_timing();
        test_bars();
        test_mode_change();
        test_grid();
`ifdef PATTERN_SCROLL_EN
        test_scroll();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
